// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Wide (4*NIBBLES-bit) adder/subtractor built by time-multiplexing a single
// 4-bit adder, one nibble per clock, LSB nibble first. The carry between
// nibbles is held in a register. A start/busy/done handshake allows one
// operation in flight at a time.
//
// Optional feature macro: NIBBLE_SEQ_SUB_EN
//   defined   : 'sub' selects A-B (B inverted, carry-in forced to 1)
//   undefined : subtract logic removed, 'sub' ignored, always A+B
//
// Ports:
//   clk    in   1  system clock, all state changes on the rising edge
//   rst    in   1  synchronous active-high reset, wins over start
//   start  in   1  operation request, sampled only while idle
//   a      in   W  operand A, captured on the accepting edge
//   b      in   W  operand B, captured on the accepting edge
//   sub    in   1  1 = A-B (only with NIBBLE_SEQ_SUB_EN), captured on accept
//   busy   out  1  high while an operation runs and during the done cycle
//   done   out  1  one-cycle pulse, result outputs valid
//   sum    out  W  registered result, held until the next result
//   cout   out  1  carry out of the MSB nibble (subtract: 1 = no borrow)
//   ovf    out  1  two's-complement signed overflow
//
// W = 4*NIBBLES, NIBBLES legal range 2..8.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// adder_4bit
//
// Plain 4-bit ripple adder with carry in/out; the only arithmetic element
// the sequencer uses.
//
// Ports:
//   a_i     in   4  addend
//   b_i     in   4  addend
//   cin_i   in   1  carry in
//   sum_o   out  4  sum bits
//   cout_o  out  1  carry out
// -----------------------------------------------------------------------------
module adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Sequencer states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     a_q,     a_d;      // operand A, shifted right per nibble
    logic [W-1:0]     b_q,     b_d;      // effective operand B (maybe inverted)
    logic             carry_q, carry_d;  // inter-nibble carry
    logic [W-1:0]     acc_q,   acc_d;    // partial result, filled from the top
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    // -------------------------------------------------------------------------
    // Operand load values (add vs. subtract)
    // -------------------------------------------------------------------------
    logic [W-1:0] b_load;
    logic         cin_load;

`ifdef NIBBLE_SEQ_SUB_EN
    // A-B is formed as A + ~B + 1: invert B once at load time and seed the
    // carry register with 1 so the first nibble supplies the +1.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub;
`else
    logic unused_sub;

    assign b_load     = b;
    assign cin_load   = 1'b0;
    assign unused_sub = sub;
`endif

    // -------------------------------------------------------------------------
    // Shared 4-bit adder: always works on the low nibble of the operand
    // shift registers, so the current nibble never needs a mux on idx.
    // -------------------------------------------------------------------------
    logic [3:0] add_sum;
    logic       add_cout;

    adder_4bit u_adder (
        .a_i    (a_q[3:0]),
        .b_i    (b_q[3:0]),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Result shift register with this cycle's nibble inserted at the top;
    // after NIBBLES shifts the LSB nibble has reached bits [3:0].
    logic [W-1:0] acc_shift;
    assign acc_shift = {add_sum, acc_q[W-1:4]};

    // On the final nibble the adder inputs are the operand MSB nibbles, so
    // bit 3 of each is the sign bit. Overflow: operands agree in sign but
    // the result sign differs.
    logic ovf_last;
    assign ovf_last = (a_q[3] == b_q[3]) && (add_sum[3] != a_q[3]);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = cin_load;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                acc_d   = acc_shift;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_ONE;

                if (idx_q == IDX_LAST) begin
                    sum_d   = acc_shift;
                    cout_d  = add_cout;
                    ovf_d   = ovf_last;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // 'start' is deliberately not looked at here: requests made
                // during an operation are dropped, not queued.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath shift registers are ordinary flops, not a
        // memory array, so clearing them on reset is cheap and keeps a
        // reset mid-operation from leaving stale operands behind.
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update
            // from the pre-edge values, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES = 4). Each
// accepted operation pushes its expected result, computed with plain wide
// integer arithmetic, into a queue; an independent monitor pops and
// compares whenever 'done' is seen. Directed cases, an ignored mid-run
// start, a mid-run reset and a block of random operations are applied.
// Honours NIBBLE_SEQ_SUB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

`ifdef NIBBLE_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: unsigned and signed integer arithmetic on the whole words.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        res_t   e;
        longint ux, uy, ur, sx, sy, sr;
        logic   do_sub;
        do_sub = s && SUB_EN;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (do_sub) begin
            ur     = ux - uy;
            sr     = sx - sy;
            e.cout = (ux >= uy);
        end else begin
            ur     = ux + uy;
            sr     = sx + sy;
            e.cout = ur[W];
        end
        e.sum = ur[W-1:0];
        e.ovf = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every done pulse against the oldest pending result.
    initial begin : monitor
        res_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_during_done", {31'd0, busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with no pending result");
                end else begin
                    e = exp_q.pop_front();
                    check("sum", {16'd0, sum}, {16'd0, e.sum});
                    check("cout", {31'd0, cout}, {31'd0, e.cout});
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                end
            end
            prev_done = done;
        end
    end

    // One full operation; returns the negedge index (1 = first after the
    // accepting edge) where done was seen and the number of busy cycles.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1 && lat == 0) lat = k;
            if (busy === 1'b1) bcnt++;
            else break;
            @(negedge clk);
        end
    endtask

    task automatic op_checked(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic s);
        int lat, bcnt;
        run_op(x, y, s, lat, bcnt);
        check("done_latency", lat, NIBBLES + 1);
        check("busy_cycles", bcnt, NIBBLES + 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;

        // Directed cases.
        op_checked(16'h1234, 16'h0FFF, 1'b0);
        op_checked(16'hFFFF, 16'h0001, 1'b0);
        op_checked(16'h7FFF, 16'h0001, 1'b0);
        op_checked(16'h0005, 16'h0007, 1'b1);
        op_checked(16'h8000, 16'h8000, 1'b0);
        op_checked(16'h0000, 16'h8000, 1'b1);

        // A start raised during RUN is dropped.
        d0 = done_cnt;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(16'h0001, 16'h0001, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("ignored_start_done_count", done_cnt - d0, 1);
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Reset during the second RUN cycle aborts the operation.
        d0 = done_cnt;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        op_checked(16'h00FF, 16'h0001, 1'b0);

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            op_checked(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
